// File: rtl/kmkz_trap_ctrl_pkg.sv
// kmkz_trap_ctrl_pkg: CSR addresses, cause codes and bit indices shared by the trap controller
package kmkz_trap_ctrl_pkg;
  localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ID_MIE     = 12'h304;
  localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_ID_MIP     = 12'h344;
  localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
  localparam logic [4:0] CAUSE_BREAK    = 5'd3;
  localparam logic [4:0] CAUSE_LD_ALIGN = 5'd4;
  localparam logic [4:0] CAUSE_ST_ALIGN = 5'd6;
  localparam logic [4:0] CAUSE_MTIP     = 5'd7;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MTIP     = 7;
  typedef enum logic {ST_RUN, ST_HANDLER} state_e;
endpackage

// File: rtl/kmkz_trap_ctrl_if.sv
// kmkz_trap_ctrl_if: X-stage, exception and CSR-read signals between pipeline and trap controller
interface kmkz_trap_ctrl_if;
  logic        x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] x_csr_write_value_i, x_exception_pc_i, csr_mtvec_i;
  logic        exp_tick_i, exp_invalid_insn_i, exp_breakpoint_i, exp_unaligned_load_i, exp_unaligned_store_i;
  logic        x_exception_o, x_double_fault_o;
  logic [31:0] x_exception_vector_o, x_exception_pc_o;
  logic [31:0] csr_mstatus_o, csr_mie_o, csr_mip_o, csr_mepc_o, csr_mcause_o;
  modport master (
    output x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i, d_csr_sel_i, x_csr_write_value_i,
           x_exception_pc_i, csr_mtvec_i, exp_tick_i, exp_invalid_insn_i, exp_breakpoint_i,
           exp_unaligned_load_i, exp_unaligned_store_i,
    input  x_exception_o, x_double_fault_o, x_exception_vector_o, x_exception_pc_o,
           csr_mstatus_o, csr_mie_o, csr_mip_o, csr_mepc_o, csr_mcause_o
  );
  modport slave (
    input  x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i, d_csr_sel_i, x_csr_write_value_i,
           x_exception_pc_i, csr_mtvec_i, exp_tick_i, exp_invalid_insn_i, exp_breakpoint_i,
           exp_unaligned_load_i, exp_unaligned_store_i,
    output x_exception_o, x_double_fault_o, x_exception_vector_o, x_exception_pc_o,
           csr_mstatus_o, csr_mie_o, csr_mip_o, csr_mepc_o, csr_mcause_o
  );
endinterface

// File: rtl/kmkz_trap_ctrl_irq_prio.sv
// kmkz_irq_prio: fixed-priority encoder, lowest line wins, code = 16 + line index
module kmkz_irq_prio #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [4:0]         o_code
);
  always_comb begin
    o_code = 5'd16;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (i_req[k]) o_code = 5'(16 + k);
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/kmkz_trap_ctrl.sv
// kmkz_trap_ctrl: machine-mode trap controller with external IRQ lines, MIE/MPIE stacking and double-fault detect
module kmkz_trap_ctrl
  import kmkz_trap_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  kmkz_trap_ctrl_if.slave    bus
);
  state_e              r_state, w_state_nxt;
  logic [NUM_IRQ-1:0]  r_irq_q, r_edge_pend, r_irq_en, w_line_pend, w_mip_keep;
  logic                r_mie, r_mpie, r_mtip, r_mtie, r_df;
  logic [31:0]         r_mepc, r_mcause, w_mip, w_mie, w_base, w_cause, w_wv;
  logic                w_commit, w_sync, w_irq_rdy, w_exc, w_take, w_dfault, w_eret, w_csr_wr, w_mip_wr;
  logic                w_prio_valid;
  logic [4:0]          w_prio_code, w_code;
  assign w_commit    = !bus.x_stall_i & !bus.x_kill_i;
  assign w_sync      = bus.exp_invalid_insn_i | bus.exp_breakpoint_i | bus.exp_unaligned_load_i | bus.exp_unaligned_store_i;
  assign w_line_pend = (r_edge_pend & EDGE_MASK) | (irq_i & ~EDGE_MASK);
  assign w_mip       = (32'(w_line_pend) << 16) | (32'(r_mtip) << MIP_MTIP);
  assign w_mie       = (32'(r_irq_en) << 16) | (32'(r_mtie) << MIP_MTIP);
  assign w_wv        = bus.x_csr_write_value_i;
  kmkz_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .i_req   (w_line_pend & r_irq_en),
    .o_valid (w_prio_valid),
    .o_code  (w_prio_code)
  );
  assign w_irq_rdy = r_mie & ((r_mtip & r_mtie) | w_prio_valid);
  always_comb begin
    w_exc       = (r_state == ST_RUN) & (w_sync | w_irq_rdy);
    w_take      = w_commit & w_exc;
    w_dfault    = w_commit & (r_state == ST_HANDLER) & w_sync;
    w_eret      = w_commit & (r_state == ST_HANDLER) & bus.d_is_eret_i & !w_sync;
    w_state_nxt = w_take ? ST_HANDLER : w_eret ? ST_RUN : r_state;
  end
  assign w_csr_wr   = w_commit & bus.d_is_csr_i & !w_take & !w_dfault;
  assign w_mip_wr   = w_csr_wr & (bus.d_csr_sel_i == CSR_ID_MIP);
  assign w_mip_keep = w_mip_wr ? w_wv[16 +: NUM_IRQ] : '1;
  assign w_code = bus.exp_invalid_insn_i    ? CAUSE_ILLEGAL  :
                  bus.exp_breakpoint_i      ? CAUSE_BREAK    :
                  bus.exp_unaligned_load_i  ? CAUSE_LD_ALIGN :
                  bus.exp_unaligned_store_i ? CAUSE_ST_ALIGN :
                  (r_mtip & r_mtie)         ? CAUSE_MTIP     : w_prio_code;
  assign w_cause = {!w_sync, 26'b0, w_code};
  assign w_base  = {bus.csr_mtvec_i[31:2], 2'b00};
  assign bus.x_exception_o        = w_exc;
  assign bus.x_exception_vector_o = (!w_sync & bus.csr_mtvec_i[1:0] == 2'b01) ? w_base + {25'b0, w_code, 2'b00} : w_base;
  assign bus.x_exception_pc_o     = r_mepc;
  assign bus.x_double_fault_o     = r_df;
  assign bus.csr_mstatus_o        = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign bus.csr_mie_o            = w_mie;
  assign bus.csr_mip_o            = w_mip;
  assign bus.csr_mepc_o           = r_mepc;
  assign bus.csr_mcause_o         = r_mcause;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_RUN;
      r_irq_q     <= '0;
      r_edge_pend <= '0;
      r_irq_en    <= '0;
      r_mtie      <= 1'b0;
      r_mtip      <= 1'b0;
      r_mie       <= 1'b0;
      r_mpie      <= 1'b0;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_df        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_irq_q     <= irq_i;
      r_edge_pend <= EDGE_MASK & ((irq_i & ~r_irq_q) | (r_edge_pend & w_mip_keep));
      r_mtip      <= bus.exp_tick_i | (r_mtip & (w_mip_wr ? w_wv[MIP_MTIP] : 1'b1));
      if (w_dfault) r_df <= 1'b1;
      if (w_take) begin
        r_mepc   <= bus.x_exception_pc_i;
        r_mcause <= w_cause;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (w_eret) begin
        r_mie    <= r_mpie;
        r_mpie   <= 1'b1;
      end else if (w_csr_wr) begin
        if (bus.d_csr_sel_i == CSR_ID_MSTATUS) begin
          r_mie  <= w_wv[MSTATUS_MIE];
          r_mpie <= w_wv[MSTATUS_MPIE];
        end
        if (bus.d_csr_sel_i == CSR_ID_MIE) begin
          r_irq_en <= w_wv[16 +: NUM_IRQ];
          r_mtie   <= w_wv[MIP_MTIP];
        end
        if (bus.d_csr_sel_i == CSR_ID_MEPC) r_mepc <= w_wv;
        if (bus.d_csr_sel_i == CSR_ID_MCAUSE) r_mcause <= w_wv;
      end
    end
  end
endmodule

// File: tb/tb_kmkz_trap_ctrl.sv
// tb_kmkz_trap_ctrl: directed scenarios for the trap controller, line 1 edge-triggered, others level
module tb_kmkz_trap_ctrl;
  import kmkz_trap_ctrl_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  int         n_chk = 0;
  int         n_fail = 0;
  kmkz_trap_ctrl_if bus();
  kmkz_trap_ctrl #(.NUM_IRQ(8), .EDGE_MASK(8'h02)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .irq_i (irq),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.x_stall_i = 0; bus.x_kill_i = 0; bus.d_is_csr_i = 0; bus.d_is_eret_i = 0;
    bus.d_csr_sel_i = '0; bus.x_csr_write_value_i = '0; bus.x_exception_pc_i = '0;
    bus.exp_tick_i = 0; bus.exp_invalid_insn_i = 0; bus.exp_breakpoint_i = 0;
    bus.exp_unaligned_load_i = 0; bus.exp_unaligned_store_i = 0;
  endtask
  task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
    bus.d_is_csr_i = 1; bus.d_csr_sel_i = a; bus.x_csr_write_value_i = v;
    cyc();
    bus.d_is_csr_i = 0;
  endtask
  task automatic mret();
    bus.d_is_eret_i = 1;
    cyc();
    bus.d_is_eret_i = 0;
  endtask
  task automatic test_reset();
    #1;
    n_chk++; if (bus.csr_mstatus_o !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus got %h want %h", bus.csr_mstatus_o, 32'h1800); end
    n_chk++; if (bus.csr_mie_o !== 32'h0) begin n_fail++; $display("FAIL reset_mie got %h want 0", bus.csr_mie_o); end
    n_chk++; if (bus.csr_mip_o !== 32'h0) begin n_fail++; $display("FAIL reset_mip got %h want 0", bus.csr_mip_o); end
    n_chk++; if (bus.csr_mcause_o !== 32'h0) begin n_fail++; $display("FAIL reset_mcause got %h want 0", bus.csr_mcause_o); end
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b want 0", bus.x_exception_o); end
    n_chk++; if (bus.x_double_fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_df got %b want 0", bus.x_double_fault_o); end
  endtask
  task automatic test_edge_vectored();
    bus.csr_mtvec_i = 32'h101;
    csr_write(CSR_ID_MSTATUS, 32'h8);
    csr_write(CSR_ID_MIE, 32'h0002_0000);
    n_chk++; if (bus.csr_mie_o !== 32'h0002_0000) begin n_fail++; $display("FAIL edge_mie got %h want %h", bus.csr_mie_o, 32'h0002_0000); end
    n_chk++; if (bus.csr_mstatus_o !== 32'h1808) begin n_fail++; $display("FAIL edge_mstatus got %h want %h", bus.csr_mstatus_o, 32'h1808); end
    irq = 8'h02;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL edge_same_cycle got %b want 0", bus.x_exception_o); end
    cyc();
    irq = 8'h00;
    bus.x_exception_pc_i = 32'h1234;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b1) begin n_fail++; $display("FAIL edge_exc got %b want 1", bus.x_exception_o); end
    n_chk++; if (bus.x_exception_vector_o !== 32'h144) begin n_fail++; $display("FAIL edge_vector got %h want %h", bus.x_exception_vector_o, 32'h144); end
    n_chk++; if (bus.csr_mip_o !== 32'h0002_0000) begin n_fail++; $display("FAIL edge_mip got %h want %h", bus.csr_mip_o, 32'h0002_0000); end
    cyc();
    n_chk++; if (bus.csr_mcause_o !== 32'h8000_0011) begin n_fail++; $display("FAIL edge_mcause got %h want %h", bus.csr_mcause_o, 32'h8000_0011); end
    n_chk++; if (bus.csr_mepc_o !== 32'h1234) begin n_fail++; $display("FAIL edge_mepc got %h want %h", bus.csr_mepc_o, 32'h1234); end
    n_chk++; if (bus.csr_mstatus_o !== 32'h1880) begin n_fail++; $display("FAIL edge_mstatus_trap got %h want %h", bus.csr_mstatus_o, 32'h1880); end
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL edge_handler_exc got %b want 0", bus.x_exception_o); end
    csr_write(CSR_ID_MIP, 32'h0);
    n_chk++; if (bus.csr_mip_o !== 32'h0) begin n_fail++; $display("FAIL edge_mip_clear got %h want 0", bus.csr_mip_o); end
    mret();
    n_chk++; if (bus.csr_mstatus_o !== 32'h1888) begin n_fail++; $display("FAIL edge_mret_mstatus got %h want %h", bus.csr_mstatus_o, 32'h1888); end
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL edge_mret_exc got %b want 0", bus.x_exception_o); end
  endtask
  task automatic test_level_prio();
    csr_write(CSR_ID_MIE, 32'h0009_0000);
    irq = 8'h09;
    #1;
    n_chk++; if (bus.x_exception_vector_o !== 32'h140) begin n_fail++; $display("FAIL level_vec16 got %h want %h", bus.x_exception_vector_o, 32'h140); end
    cyc();
    n_chk++; if (bus.csr_mcause_o !== 32'h8000_0010) begin n_fail++; $display("FAIL level_code16 got %h want %h", bus.csr_mcause_o, 32'h8000_0010); end
    irq = 8'h08;
    bus.d_is_eret_i = 1;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL level_mret_cycle got %b want 0", bus.x_exception_o); end
    cyc();
    bus.d_is_eret_i = 0;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b1) begin n_fail++; $display("FAIL level_after_mret got %b want 1", bus.x_exception_o); end
    n_chk++; if (bus.x_exception_vector_o !== 32'h14C) begin n_fail++; $display("FAIL level_vec19 got %h want %h", bus.x_exception_vector_o, 32'h14C); end
    cyc();
    n_chk++; if (bus.csr_mcause_o !== 32'h8000_0013) begin n_fail++; $display("FAIL level_code19 got %h want %h", bus.csr_mcause_o, 32'h8000_0013); end
    irq = 8'h00;
    mret();
  endtask
  task automatic test_sync_stall();
    bus.x_stall_i = 1; bus.exp_invalid_insn_i = 1; bus.exp_breakpoint_i = 1; bus.exp_tick_i = 1;
    bus.x_exception_pc_i = 32'h2000;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b1) begin n_fail++; $display("FAIL sync_exc got %b want 1", bus.x_exception_o); end
    n_chk++; if (bus.x_exception_vector_o !== 32'h100) begin n_fail++; $display("FAIL sync_vector got %h want %h", bus.x_exception_vector_o, 32'h100); end
    cyc();
    bus.exp_tick_i = 0;
    n_chk++; if (bus.csr_mcause_o !== 32'h8000_0013) begin n_fail++; $display("FAIL stall_mcause got %h want %h", bus.csr_mcause_o, 32'h8000_0013); end
    n_chk++; if (bus.csr_mstatus_o !== 32'h1888) begin n_fail++; $display("FAIL stall_mstatus got %h want %h", bus.csr_mstatus_o, 32'h1888); end
    n_chk++; if (bus.csr_mip_o !== 32'h80) begin n_fail++; $display("FAIL stall_mtip got %h want %h", bus.csr_mip_o, 32'h80); end
    bus.x_stall_i = 0;
    cyc();
    bus.exp_invalid_insn_i = 0; bus.exp_breakpoint_i = 0;
    n_chk++; if (bus.csr_mcause_o !== 32'h2) begin n_fail++; $display("FAIL sync_mcause got %h want %h", bus.csr_mcause_o, 32'h2); end
    n_chk++; if (bus.csr_mepc_o !== 32'h2000) begin n_fail++; $display("FAIL sync_mepc got %h want %h", bus.csr_mepc_o, 32'h2000); end
  endtask
  task automatic test_double_fault();
    bus.exp_unaligned_store_i = 1;
    bus.x_exception_pc_i = 32'h3000;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL df_exc got %b want 0", bus.x_exception_o); end
    cyc();
    bus.exp_unaligned_store_i = 0;
    n_chk++; if (bus.x_double_fault_o !== 1'b1) begin n_fail++; $display("FAIL df_flag got %b want 1", bus.x_double_fault_o); end
    n_chk++; if (bus.csr_mepc_o !== 32'h2000) begin n_fail++; $display("FAIL df_mepc got %h want %h", bus.csr_mepc_o, 32'h2000); end
    n_chk++; if (bus.csr_mcause_o !== 32'h2) begin n_fail++; $display("FAIL df_mcause got %h want %h", bus.csr_mcause_o, 32'h2); end
    mret();
    n_chk++; if (bus.csr_mstatus_o !== 32'h1888) begin n_fail++; $display("FAIL df_mret_mstatus got %h want %h", bus.csr_mstatus_o, 32'h1888); end
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL df_mtip_masked got %b want 0", bus.x_exception_o); end
  endtask
  task automatic test_edge_clear_race();
    csr_write(CSR_ID_MIE, 32'h0);
    irq = 8'h02;
    csr_write(CSR_ID_MIP, 32'h0);
    irq = 8'h00;
    n_chk++; if (bus.csr_mip_o !== 32'h0002_0000) begin n_fail++; $display("FAIL race_mip got %h want %h", bus.csr_mip_o, 32'h0002_0000); end
    bus.exp_invalid_insn_i = 1;
    bus.x_exception_pc_i = 32'h4000;
    csr_write(CSR_ID_MIE, 32'h0002_0000);
    bus.exp_invalid_insn_i = 0;
    n_chk++; if (bus.csr_mie_o !== 32'h0) begin n_fail++; $display("FAIL trap_csr_mie got %h want 0", bus.csr_mie_o); end
    n_chk++; if (bus.csr_mepc_o !== 32'h4000) begin n_fail++; $display("FAIL trap_csr_mepc got %h want %h", bus.csr_mepc_o, 32'h4000); end
    n_chk++; if (bus.csr_mstatus_o !== 32'h1880) begin n_fail++; $display("FAIL trap_csr_mstatus got %h want %h", bus.csr_mstatus_o, 32'h1880); end
  endtask
  task automatic test_async_reset();
    bus.csr_mtvec_i = 32'h0;
    #2;
    rst_n = 0;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b0) begin n_fail++; $display("FAIL areset_exc got %b want 0", bus.x_exception_o); end
    n_chk++; if (bus.x_double_fault_o !== 1'b0) begin n_fail++; $display("FAIL areset_df got %b want 0", bus.x_double_fault_o); end
    n_chk++; if (bus.csr_mstatus_o !== 32'h1800) begin n_fail++; $display("FAIL areset_mstatus got %h want %h", bus.csr_mstatus_o, 32'h1800); end
    n_chk++; if (bus.csr_mip_o !== 32'h0) begin n_fail++; $display("FAIL areset_mip got %h want 0", bus.csr_mip_o); end
    n_chk++; if (bus.x_exception_pc_o !== 32'h0) begin n_fail++; $display("FAIL areset_mepc got %h want 0", bus.x_exception_pc_o); end
    n_chk++; if (bus.csr_mcause_o !== 32'h0) begin n_fail++; $display("FAIL areset_mcause got %h want 0", bus.csr_mcause_o); end
    n_chk++; if (bus.x_exception_vector_o !== 32'h0) begin n_fail++; $display("FAIL areset_vector got %h want 0", bus.x_exception_vector_o); end
    cyc();
    rst_n = 1;
    cyc();
    bus.exp_invalid_insn_i = 1;
    #1;
    n_chk++; if (bus.x_exception_o !== 1'b1) begin n_fail++; $display("FAIL areset_state_run got %b want 1", bus.x_exception_o); end
    bus.exp_invalid_insn_i = 0;
  endtask
  initial begin
    idle();
    irq = '0;
    bus.csr_mtvec_i = '0;
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    test_reset();
    test_edge_vectored();
    test_level_prio();
    test_sync_stall();
    test_double_fault();
    test_edge_clear_race();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
